// File: rtl/gg_cordic.sv
// gg_cordic: vectoring-mode CORDIC Givens generator.
// Drives y toward zero over N_GROUPS*D_WIDTH micro-rotations, D_WIDTH per cycle.
// Streams direction groups to the downstream GR row and reports the gain-compensated magnitude.
module gg_cordic #(
    parameter int unsigned             DATA_WIDTH = 20,
    parameter int unsigned             D_WIDTH    = 4,
    parameter int unsigned             N_GROUPS   = 3,
    parameter logic [DATA_WIDTH-1:0]   K          = 20'b0000000000_1001101101
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [DATA_WIDTH-1:0]  x_i,
    input  logic signed [DATA_WIDTH-1:0]  y_i,
    input  logic                          valid_i,
    input  logic                          clr_i,
    output logic                          busy_o,
    output logic [D_WIDTH-1:0]            d_o,
    output logic                          valid_o,
    output logic                          rotates_o,
    output logic signed [DATA_WIDTH-1:0]  r_o,
    output logic                          r_valid_o
);

    localparam int unsigned FRAC_W = 10;
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W  = (N_GROUPS > 1) ? $clog2(N_GROUPS + 1) : 1;
    localparam int unsigned SH_W   = (N_GROUPS * D_WIDTH > 1) ? $clog2(N_GROUPS * D_WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ITER  = 2'd1;
    localparam logic [1:0] S_SCALE = 2'd2;

    logic [1:0]                   r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic signed [DATA_WIDTH-1:0] r_x;
    logic signed [DATA_WIDTH-1:0] r_y;

    logic [1:0]                   w_state_nxt;
    logic [CNT_W-1:0]             w_cnt_nxt;
    logic signed [DATA_WIDTH-1:0] w_x_nxt;
    logic signed [DATA_WIDTH-1:0] w_y_nxt;
    logic [D_WIDTH-1:0]           w_d_nxt;
    logic                         w_valid_nxt;
    logic                         w_rot_nxt;
    logic signed [DATA_WIDTH-1:0] w_r_nxt;
    logic                         w_rv_nxt;
    logic                         w_busy_nxt;

    logic [D_WIDTH-1:0]           w_grp;
    logic signed [DATA_WIDTH-1:0] w_x_chain;
    logic signed [DATA_WIDTH-1:0] w_y_chain;

    logic signed [PROD_W-1:0]     w_x_ext;
    logic signed [PROD_W-1:0]     w_k_ext;
    logic signed [PROD_W-1:0]     w_prod;
    logic [DATA_WIDTH-2:0]        w_prod_mid;

    // Unrolled micro-rotation chain; stage j uses shift index cnt*D_WIDTH + j.
    for (genvar j = 0; j < int'(D_WIDTH); j++) begin : g_rot
        logic signed [DATA_WIDTH-1:0] w_xi;
        logic signed [DATA_WIDTH-1:0] w_yi;
        logic signed [DATA_WIDTH-1:0] w_xs;
        logic signed [DATA_WIDTH-1:0] w_ys;
        logic signed [DATA_WIDTH-1:0] w_xo;
        logic signed [DATA_WIDTH-1:0] w_yo;
        logic [SH_W-1:0]              w_sh;
        logic                         w_dj;

        if (j == 0) begin : g_first
            assign w_xi = r_x;
            assign w_yi = r_y;
        end else begin : g_next
            assign w_xi = g_rot[j-1].w_xo;
            assign w_yi = g_rot[j-1].w_yo;
        end

        assign w_sh     = SH_W'(int'(r_cnt) * int'(D_WIDTH) + j);
        assign w_xs     = w_xi >>> w_sh;
        assign w_ys     = w_yi >>> w_sh;
        assign w_dj     = w_xi[DATA_WIDTH-1] ^ w_yi[DATA_WIDTH-1];
        assign w_xo     = w_dj ? (w_xi - w_ys) : (w_xi + w_ys);
        assign w_yo     = w_dj ? (w_yi + w_xs) : (w_yi - w_xs);
        assign w_grp[j] = w_dj;
    end

    assign w_x_chain = g_rot[D_WIDTH-1].w_xo;
    assign w_y_chain = g_rot[D_WIDTH-1].w_yo;

    // Gain compensation: full signed product, keep sign plus the integer/fraction window.
    assign w_x_ext    = {{DATA_WIDTH{r_x[DATA_WIDTH-1]}}, r_x};
    assign w_k_ext    = {{DATA_WIDTH{K[DATA_WIDTH-1]}}, K};
    assign w_prod     = w_x_ext * w_k_ext;
    assign w_prod_mid = (DATA_WIDTH-1)'(w_prod >>> FRAC_W);

    // Next-state and next-output logic; clr_i returns everything to the reset image.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_d_nxt     = d_o;
        w_valid_nxt = 1'b0;
        w_rot_nxt   = rotates_o;
        w_r_nxt     = r_o;
        w_rv_nxt    = 1'b0;
        w_busy_nxt  = busy_o;

        if (clr_i) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_d_nxt     = '0;
            w_rot_nxt   = 1'b0;
            w_r_nxt     = '0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        w_x_nxt     = x_i;
                        w_y_nxt     = y_i;
                        w_cnt_nxt   = '0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_ITER;
                    end
                end
                S_ITER: begin
                    w_x_nxt     = w_x_chain;
                    w_y_nxt     = w_y_chain;
                    w_d_nxt     = w_grp;
                    w_valid_nxt = (r_cnt == '0);
                    w_rot_nxt   = 1'b1;
                    w_cnt_nxt   = CNT_W'(r_cnt + 1'b1);
                    if (r_cnt == CNT_W'(N_GROUPS - 1)) begin
                        w_state_nxt = S_SCALE;
                    end
                end
                S_SCALE: begin
                    w_r_nxt     = {w_prod[PROD_W-1], w_prod_mid};
                    w_rv_nxt    = 1'b1;
                    w_rot_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            d_o       <= '0;
            valid_o   <= 1'b0;
            rotates_o <= 1'b0;
            r_o       <= '0;
            r_valid_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            d_o       <= w_d_nxt;
            valid_o   <= w_valid_nxt;
            rotates_o <= w_rot_nxt;
            r_o       <= w_r_nxt;
            r_valid_o <= w_rv_nxt;
            busy_o    <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_gg_cordic.sv
// tb_gg_cordic: directed vectors for the Givens-generation CORDIC cell.
module tb_gg_cordic;

    logic               clk;
    logic               rst_n;
    logic signed [19:0] x_i;
    logic signed [19:0] y_i;
    logic               valid_i;
    logic               clr_i;
    logic               busy_o;
    logic [3:0]         d_o;
    logic               valid_o;
    logic               rotates_o;
    logic signed [19:0] r_o;
    logic               r_valid_o;

    int n_vec;
    int n_bad;

    gg_cordic dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_i       (x_i),
        .y_i       (y_i),
        .valid_i   (valid_i),
        .clr_i     (clr_i),
        .busy_o    (busy_o),
        .d_o       (d_o),
        .valid_o   (valid_o),
        .rotates_o (rotates_o),
        .r_o       (r_o),
        .r_valid_o (r_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // All outputs at their reset/clear image.
    task automatic chk_zero(input string tag);
        chk({tag, ".busy"},  32'(busy_o),    32'd0);
        chk({tag, ".d"},     32'(d_o),       32'd0);
        chk({tag, ".valid"}, 32'(valid_o),   32'd0);
        chk({tag, ".rot"},   32'(rotates_o), 32'd0);
        chk({tag, ".r"},     32'(r_o),       32'd0);
        chk({tag, ".rv"},    32'(r_valid_o), 32'd0);
    endtask

    // One isolated operation, checked cycle by cycle from accept (E0) through E5.
    task automatic run_op(input string nm, input logic [19:0] xv, input logic [19:0] yv,
                          input logic [3:0] g0, input logic [3:0] g1, input logic [3:0] g2,
                          input int rexp, input int rnom, input bit chk_y);
        logic signed [19:0] yres;
        int                 diff;
        @(negedge clk);
        x_i = xv; y_i = yv; valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        chk({nm, ".E0.busy"},  32'(busy_o),    32'd1);
        chk({nm, ".E0.valid"}, 32'(valid_o),   32'd0);
        @(negedge clk);
        chk({nm, ".E1.d"},     32'(d_o),       32'(g0));
        chk({nm, ".E1.valid"}, 32'(valid_o),   32'd1);
        chk({nm, ".E1.rot"},   32'(rotates_o), 32'd1);
        @(negedge clk);
        chk({nm, ".E2.d"},     32'(d_o),       32'(g1));
        chk({nm, ".E2.valid"}, 32'(valid_o),   32'd0);
        chk({nm, ".E2.rot"},   32'(rotates_o), 32'd1);
        @(negedge clk);
        chk({nm, ".E3.d"},     32'(d_o),       32'(g2));
        chk({nm, ".E3.rot"},   32'(rotates_o), 32'd1);
        chk({nm, ".E3.busy"},  32'(busy_o),    32'd1);
        chk({nm, ".E3.rv"},    32'(r_valid_o), 32'd0);
        if (chk_y) begin
            yres = dut.r_y;
            if (yres < 0) yres = -yres;
            chk({nm, ".E3.yres_lt4"}, 32'(yres < 20'sd4), 32'd1);
        end
        @(negedge clk);
        chk({nm, ".E4.rot"},   32'(rotates_o), 32'd0);
        chk({nm, ".E4.d"},     32'(d_o),       32'(g2));
        chk({nm, ".E4.r"},     32'(r_o),       32'(rexp));
        chk({nm, ".E4.rv"},    32'(r_valid_o), 32'd1);
        chk({nm, ".E4.busy"},  32'(busy_o),    32'd0);
        diff = int'(r_o) - rnom;
        if (diff < 0) diff = -diff;
        chk({nm, ".E4.r_tol8"}, 32'(diff <= 8), 32'd1);
        @(negedge clk);
        chk({nm, ".E5.rv"},    32'(r_valid_o), 32'd0);
        chk({nm, ".E5.r_hold"}, 32'(r_o),      32'(rexp));
    endtask

    initial begin
        int rv_cnt, rv_first, rv_second, vo_cnt, idle_bad, wait_cyc;
        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; valid_i = 1'b0; clr_i = 1'b0; x_i = '0; y_i = '0;

        // Reset, then ten idle cycles with no request.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        idle_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy_o || valid_o || r_valid_o || rotates_o) idle_bad++;
        end
        chk("idle.quiet", 32'(idle_bad), 32'd0);

        // (3,4): hand-traced groups 1100/0010/1111, x_final 8435 -> r 5115.
        run_op("op34", 20'd3072, 20'd4096, 4'b1100, 4'b0010, 4'b1111, 5115, 5120, 1'b0);
        // (1,0): groups 1110/0010/1111, x_final 1690 -> r 1024, y residual -2.
        run_op("op10", 20'd1024, 20'd0,    4'b1110, 4'b0010, 4'b1111, 1024, 1022, 1'b1);

        // Back-to-back: valid_i held high, accepts at E0 and E5 only.
        @(negedge clk);
        x_i = 20'd3072; y_i = 20'd4096; valid_i = 1'b1;
        rv_cnt = 0; rv_first = -1; rv_second = -1; vo_cnt = 0; idle_bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (r_valid_o) begin
                if (rv_cnt == 0) rv_first = k; else rv_second = k;
                rv_cnt++;
            end
            if (valid_o) vo_cnt++;
            if (valid_o && k != 1 && k != 6) idle_bad++;
            if (k >= 10 && busy_o) idle_bad++;
            if (k == 9) valid_i = 1'b0;
        end
        chk("b2b.rv_count",  32'(rv_cnt),    32'd2);
        chk("b2b.rv_first",  32'(rv_first),  32'd4);
        chk("b2b.rv_second", 32'(rv_second), 32'd9);
        chk("b2b.vo_count",  32'(vo_cnt),    32'd2);
        chk("b2b.timing",    32'(idle_bad),  32'd0);
        chk("b2b.r",         32'(r_o),       32'd5115);

        // Synchronous clear sampled at E2 of an operation.
        @(negedge clk);
        x_i = 20'd3072; y_i = 20'd4096; valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        chk_zero("clr");
        run_op("clr_op", 20'd1024, 20'd0, 4'b1110, 4'b0010, 4'b1111, 1024, 1022, 1'b1);

        // Asynchronous reset between E2 and E3.
        @(negedge clk);
        x_i = 20'd3072; y_i = 20'd4096; valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("arst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc = 0;
        idle_bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy_o || r_valid_o || valid_o) idle_bad++;
        end
        chk("arst.no_partial", 32'(idle_bad), 32'd0);
        run_op("arst_op", 20'd3072, 20'd4096, 4'b1100, 4'b0010, 4'b1111, 5115, 5120, 1'b0);

        // Bounded drain to idle.
        while (busy_o && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("final.idle", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
